seg_p2s_shifter: RTL and testbench
==================================

# seg_p2s_shifter

Serializer that sits directly downstream of the hex-to-segment encoder. It captures the 64-bit eight-digit segment image (`SEG_TXT`) on a start request. It then shifts the image MSB-first into the board's external serial-in/parallel-out shift-register chain using a generated shift clock, and pulses a latch strobe so all eight digits update at once. A one-cycle `done` pulse and a `busy` flag give the handshake back to the display controller.

## Interface
- `DATA_W`, 64: number of bits per transfer; equals the segment image width.
- `CLK_DIV`, 2: length of each `seg_clk` half-period in `clk` cycles; must be ≥1.
- `REFRESH_CYC`, 50000: idle cycles between automatic transfers. Used only with `SEG_P2S_AUTO_REFRESH_EN`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  transfer request; sampled only in IDLE.
- `SEG_TXT`  in  DATA_W  segment image from the encoder; captured on accepted start.
- `busy`  out  1  high from the accepted start through the end of LATCH.
- `done`  out  1  one-cycle pulse at transfer completion.
- `seg_clk`  out  1  shift clock to the external chain; data is taken on its rising edge.
- `seg_dt`  out  1  serial data to the external chain.
- `seg_latch`  out  1  storage-register latch strobe, active high.
- `seg_clrn`  out  1  active-low clear to the external chain.

## Operation
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - `start`=1 loads `SEG_TXT` into the internal shift register, loads the bit counter with DATA_W, clears the phase counter, and enters SHIFT.
  - `start`=0 holds IDLE.
- SHIFT:
  - Each bit lasts 2·CLK_DIV cycles.
  - `seg_dt` = shift-register MSB for the whole bit.
  - `seg_clk`=0 for the first CLK_DIV cycles and 1 for the second CLK_DIV cycles, so the rising edge is mid-bit.
  - At the end of the high phase, the register shifts left by one (zero fill) and the counter decrements.
  - When the counter reaches 0, the state goes to LATCH.
- LATCH:
  - `seg_latch`=1, `seg_clk`=0, `seg_dt`=0 for CLK_DIV cycles.
  - Then the state returns to IDLE and `done`=1 for exactly that first IDLE cycle.
- Bit order: `SEG_TXT[DATA_W-1]` is shifted first and `SEG_TXT[0]` last.
- `SEG_TXT` changes after capture have no effect on the transfer in progress.
- `start` while `busy`=1 is ignored and not queued.
- `start`=1 during the `done` cycle is accepted, because the state is already IDLE; the next transfer begins on that edge.
- `seg_clrn` is 0 during reset and rises to 1 on the first `clk` edge after `rst_n` deasserts. It stays at 1 thereafter.
- Counter widths: the bit counter is wide enough for DATA_W. The phase counter is wide enough for CLK_DIV−1. No wrap occurs within a transfer.

## Timing
- Reset values (asynchronous): state IDLE, `busy`=0, `done`=0, `seg_clk`=0, `seg_dt`=0, `seg_latch`=0, `seg_clrn`=0, shift register and counters 0.
- Let edge E be the edge that accepts `start`.
  - `busy`=1 and `seg_dt`=`SEG_TXT[DATA_W-1]` from E.
  - Bit i (i=0 first) occupies cycles E+2·CLK_DIV·i through E+2·CLK_DIV·(i+1)−1.
  - The first `seg_clk` rising edge occurs at E+CLK_DIV.
  - LATCH starts at E+2·CLK_DIV·DATA_W.
  - `done`=1 and `busy`=0 occur at E+2·CLK_DIV·DATA_W+CLK_DIV.
- Exactly DATA_W `seg_clk` rising edges and one `seg_latch` pulse occur per transfer.
- Reset asserted mid-transfer immediately forces all reset values; no `done` is produced and the partial image is not latched.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SEG_P2S_AUTO_REFRESH_EN` defined:
  - An idle counter increments in IDLE and resets to 0 on any accepted start.
  - When the counter reaches REFRESH_CYC−1 in IDLE, an internal start is generated and the current `SEG_TXT` is captured.
  - External `start` still works; both sources together count as one start.
  - The counter is held at 0 during reset, so the first automatic transfer begins REFRESH_CYC−1 cycles after reset release.
- Macro not defined: transfers begin only on external `start`; the idle counter and `REFRESH_CYC` are not implemented.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 → all outputs at reset values. `seg_clrn` rises 1 cycle after release; no transfer occurs until `start` is sampled after release.
- Single transfer, CLK_DIV=2, `SEG_TXT`=64'h8000_0000_0000_0001, `start` pulse:
  - 64 `seg_clk` rising edges.
  - Sampled `seg_dt` is 1 on edges 1 and 64 and 0 elsewhere.
  - `seg_latch` high for 2 cycles.
  - `done` at E+258, `busy` high for E..E+257.
- Pattern integrity: `SEG_TXT`=64'hC0F9_A4B0_9992_82F8 is captured by a bench-modelled 64-bit shift register on `seg_clk` and stored on `seg_latch`. The stored value must equal the input. Changing `SEG_TXT` mid-transfer must not alter it.
- Start while busy: extra `start` pulses at E+10 and E+200 → no restart, a single `done`. A `start` held high through the `done` cycle → the second transfer starts at the `done` edge.
- Reset mid-transfer: `rst_n`=0 at E+100 → immediate reset values, no `seg_latch`, no `done`. A new `start` after release gives a full 64-bit transfer.
- With `SEG_P2S_AUTO_REFRESH_EN` and REFRESH_CYC=20, no external `start`:
  - The first transfer begins 19 cycles after reset release.
  - Subsequent transfers begin 19 cycles after each `done`.
  - An external `start` at idle cycle 5 restarts the count.

Source files
------------

// File: rtl/seg_p2s_shifter.sv
// Serializes a captured segment image MSB-first into an external SIPO chain, then latches it.
// Optional feature: define SEG_P2S_AUTO_REFRESH_EN for periodic self-started transfers.
module seg_p2s_shifter #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned CLK_DIV = 2
`ifdef SEG_P2S_AUTO_REFRESH_EN
  ,
  parameter int unsigned REFRESH_CYC = 50000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] SEG_TXT,
  output logic              busy,
  output logic              done,
  output logic              seg_clk,
  output logic              seg_dt,
  output logic              seg_latch,
  output logic              seg_clrn
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned PhW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

  state_e            r_state, w_state_d;
  logic [DATA_W-1:0] r_sreg, w_sreg_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [PhW-1:0]    r_phase, w_phase_d;
  logic              r_seg_clk, w_seg_clk_d;
  logic              r_latch, w_latch_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              r_clrn;
  logic              w_start;
  logic              w_phase_last;

`ifdef SEG_P2S_AUTO_REFRESH_EN
  localparam int unsigned IdW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

  logic [IdW-1:0] r_idle_cnt, w_idle_cnt_d;
  logic           w_auto_start;

  assign w_auto_start = (r_state == StIdle) && (r_idle_cnt == IdW'(REFRESH_CYC - 1));
  assign w_start      = start | w_auto_start;

  // Counts only while idle; any accepted start (or a busy transfer) parks it at zero.
  always_comb begin
    w_idle_cnt_d = '0;
    if (r_state == StIdle && !w_start) begin
      w_idle_cnt_d = r_idle_cnt + IdW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= w_idle_cnt_d;
    end
  end
`else
  assign w_start = start;
`endif

  assign w_phase_last = (r_phase == PhW'(CLK_DIV - 1));

  always_comb begin
    w_state_d   = r_state;
    w_sreg_d    = r_sreg;
    w_cnt_d     = r_cnt;
    w_phase_d   = r_phase;
    w_seg_clk_d = r_seg_clk;
    w_latch_d   = r_latch;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_sreg_d    = SEG_TXT;
          w_cnt_d     = CntW'(DATA_W);
          w_phase_d   = '0;
          w_seg_clk_d = 1'b0;
          w_busy_d    = 1'b1;
          w_state_d   = StShift;
        end
      end
      StShift: begin
        if (w_phase_last) begin
          w_phase_d = '0;
          if (!r_seg_clk) begin
            w_seg_clk_d = 1'b1;
          end else begin
            // End of the high half: advance to the next bit.
            w_seg_clk_d = 1'b0;
            w_sreg_d    = {r_sreg[DATA_W-2:0], 1'b0};
            w_cnt_d     = r_cnt - CntW'(1);
            if (r_cnt == CntW'(1)) begin
              w_latch_d = 1'b1;
              w_state_d = StLatch;
            end
          end
        end else begin
          w_phase_d = r_phase + PhW'(1);
        end
      end
      StLatch: begin
        if (w_phase_last) begin
          w_phase_d = '0;
          w_latch_d = 1'b0;
          w_busy_d  = 1'b0;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_phase_d = r_phase + PhW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_sreg    <= '0;
      r_cnt     <= '0;
      r_phase   <= '0;
      r_seg_clk <= 1'b0;
      r_latch   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clrn    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_sreg    <= w_sreg_d;
      r_cnt     <= w_cnt_d;
      r_phase   <= w_phase_d;
      r_seg_clk <= w_seg_clk_d;
      r_latch   <= w_latch_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_clrn    <= 1'b1;
    end
  end

  // The register drains to zero by LATCH, so its MSB doubles as the registered data line.
  assign seg_dt    = r_sreg[DATA_W-1];
  assign seg_clk   = r_seg_clk;
  assign seg_latch = r_latch;
  assign busy      = r_busy;
  assign done      = r_done;
  assign seg_clrn  = r_clrn;

endmodule

// File: tb/tb_seg_p2s_shifter.sv
// Directed bench for seg_p2s_shifter (DATA_W=64, CLK_DIV=2, default build).
module tb_seg_p2s_shifter;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned CLK_DIV = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] seg_txt;
  logic              busy, done, seg_clk, seg_dt, seg_latch, seg_clrn;

  always #5 clk = ~clk;

  seg_p2s_shifter #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .SEG_TXT   (seg_txt),
    .busy      (busy),
    .done      (done),
    .seg_clk   (seg_clk),
    .seg_dt    (seg_dt),
    .seg_latch (seg_latch),
    .seg_clrn  (seg_clrn)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model of the external chain: shift on seg_clk rise, store on seg_latch rise.
  int unsigned       rises        = 0;
  int unsigned       latch_pulses = 0;
  logic [DATA_W-1:0] model_sr     = '0;
  logic [DATA_W-1:0] stored       = '0;

  always @(posedge seg_clk) begin
    rises    <= rises + 1;
    model_sr <= {model_sr[DATA_W-2:0], seg_dt};
  end

  always @(posedge seg_latch) begin
    latch_pulses <= latch_pulses + 1;
    stored       <= model_sr;
  end

  int          rel, done_rel, first_latch_rel, n_done, n_latch_cyc, n_busy_cyc;
  int unsigned rise_base, lp_base;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rel++;
    if (busy) n_busy_cyc++;
    if (seg_latch) begin
      n_latch_cyc++;
      if (first_latch_rel < 0) first_latch_rel = rel;
    end
    if (done) begin
      n_done++;
      if (done_rel < 0) done_rel = rel;
    end
  endtask

  task automatic tick_to(input int t);
    while (rel < t) tick();
  endtask

  task automatic clear_stats();
    n_done          = 0;
    n_latch_cyc     = 0;
    n_busy_cyc      = 0;
    done_rel        = -1;
    first_latch_rel = -1;
    rise_base       = rises;
    lp_base         = latch_pulses;
  endtask

  // Drives start for one cycle; afterwards rel==0 is edge E.
  task automatic start_xfer(input logic [63:0] d);
    seg_txt = d;
    start   = 1'b1;
    clear_stats();
    rel = -1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b1;
    start   = 1'b1;
    seg_txt = 64'hFFFF_FFFF_FFFF_FFFF;
    rel     = 0;
    clear_stats();
    #3 rst_n = 1'b0;
    #1;
    check("reset_outputs", {58'd0, busy, done, seg_clk, seg_dt, seg_latch, seg_clrn}, 64'd0);
    tick();
    tick();
    check("reset_hold_start", {58'd0, busy, done, seg_clk, seg_dt, seg_latch, seg_clrn}, 64'd0);

    rst_n = 1'b1;
    start = 1'b0;
    check("clrn_before_edge", {63'd0, seg_clrn}, 64'd0);
    tick();
    check("clrn_after_release", {63'd0, seg_clrn}, 64'd1);
    tick();
    tick();
    tick();
    check("no_xfer_without_start", {62'd0, busy, seg_clk}, 64'd0);

    // Single transfer with only the first and last bit set.
    start_xfer(64'h8000_0000_0000_0001);
    check("e0_busy_dt_clk", {61'd0, busy, seg_dt, seg_clk}, 64'b110);
    tick_to(2);
    check("first_rise_at_e2", {63'd0, seg_clk}, 64'd1);
    tick_to(4);
    check("bit1_dt_clk", {62'd0, seg_dt, seg_clk}, 64'd0);
    tick_to(256);
    check("latch_start_lines", {61'd0, seg_latch, seg_clk, seg_dt}, 64'b100);
    tick_to(260);
    check("t1_rises", 64'(rises - rise_base), 64'd64);
    check("t1_shifted_image", model_sr, 64'h8000_0000_0000_0001);
    check("t1_first_latch", 64'(first_latch_rel), 64'd256);
    check("t1_latch_cycles", 64'(n_latch_cyc), 64'd2);
    check("t1_done_count", 64'(n_done), 64'd1);
    check("t1_done_time", 64'(done_rel), 64'd258);
    check("t1_busy_cycles", 64'(n_busy_cyc), 64'd258);

    // Pattern integrity with SEG_TXT disturbed mid-transfer.
    start_xfer(64'hC0F9_A4B0_9992_82F8);
    tick_to(50);
    seg_txt = 64'h0123_4567_89AB_CDEF;
    tick_to(262);
    check("t2_stored", stored, 64'hC0F9_A4B0_9992_82F8);
    check("t2_rises", 64'(rises - rise_base), 64'd64);
    check("t2_latch_pulses", 64'(latch_pulses - lp_base), 64'd1);

    // Start pulses while busy are ignored.
    start_xfer(64'h5A5A_0F0F_3C3C_FFFF);
    tick_to(9);
    seg_txt = 64'hFFFF_0000_FFFF_0000;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick_to(199);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick_to(262);
    check("busy_start_done_count", 64'(n_done), 64'd1);
    check("busy_start_done_time", 64'(done_rel), 64'd258);
    check("busy_start_stored", stored, 64'h5A5A_0F0F_3C3C_FFFF);
    check("busy_start_rises", 64'(rises - rise_base), 64'd64);

    // Start held through the done cycle is accepted on the edge after it.
    start_xfer(64'h0123_4567_89AB_CDEF);
    tick_to(250);
    seg_txt = 64'hF00D_CAFE_1234_5678;
    start   = 1'b1;
    tick_to(258);
    check("held_done_cycle", {62'd0, done, busy}, 64'b10);
    tick();
    start = 1'b0;
    check("held_restart", {61'd0, busy, done, seg_dt}, 64'b101);
    tick_to(517);
    check("held_second_done", {63'd0, done}, 64'd1);
    check("held_second_stored", stored, 64'hF00D_CAFE_1234_5678);

    // Reset mid-transfer.
    start_xfer(64'hFFFF_FFFF_FFFF_FFFF);
    tick_to(100);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {58'd0, busy, done, seg_clk, seg_dt, seg_latch, seg_clrn}, 64'd0);
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick_to(300);
    check("midreset_no_done", 64'(n_done), 64'd0);
    check("midreset_no_latch", 64'(latch_pulses - lp_base), 64'd0);
    check("midreset_idle", {62'd0, busy, seg_clrn}, 64'b01);

    start_xfer(64'hA5C3_0000_1111_E7E7);
    tick_to(262);
    check("post_reset_rises", 64'(rises - rise_base), 64'd64);
    check("post_reset_stored", stored, 64'hA5C3_0000_1111_E7E7);
    check("post_reset_done_time", 64'(done_rel), 64'd258);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
